// File: rtl/memory_arbiter_pkg.sv
// Shared definitions for the memory arbiter: read-owner encoding, round-robin
// selector, default starvation limit and the GFX/DMA tie-break helper.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_GFX  = 2'd2,
    OWN_DMA  = 2'd3
  } owner_e;

  typedef enum logic {
    RR_GFX = 1'b0,
    RR_DMA = 1'b1
  } rr_sel_e;

  localparam int unsigned STARVE_LIMIT_DEFAULT = 8;

  // True when GFX should win among the GFX/DMA requests given the last winner.
  function automatic logic rr_pick_gfx(input logic gfx_req, input logic dma_req,
                                       input rr_sel_e rr_last);
    if (gfx_req && dma_req) return (rr_last == RR_DMA);
    return gfx_req;
  endfunction

endpackage

// File: rtl/starve_counter.sv
// Saturating 8-bit wait counter; flags a requester that has waited LIMIT cycles.
module starve_counter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic valid_i,
  input  logic grant_i,
  output logic over_o
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (!valid_i || grant_i) count_d = '0;
    else if (count_q != 8'hFF) count_d = count_q + 8'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) count_q <= '0;
    else          count_q <= count_d;
  end

  // Only a live request may preempt; a stale count from a dropped request must not.
  assign over_o = valid_i && (count_q >= 8'(LIMIT));

endmodule

// File: rtl/memory_arbiter.sv
// Single-port SPRAM arbiter: CPU first, GFX/DMA round-robin, one access per clock.
// Optional starvation guard enabled by defining MEMORY_ARBITER_STARVE_GUARD_EN.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned ADDRESS_BITS = 15,
  parameter int unsigned BITS         = 16,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic                    CLK,
  input  logic                    RSTb,
  input  logic                    CPU_VALID,
  input  logic [ADDRESS_BITS-1:0] CPU_ADDR,
  input  logic                    CPU_WR,
  input  logic [BITS-1:0]         CPU_WDATA,
  input  logic                    GFX_VALID,
  input  logic [ADDRESS_BITS-1:0] GFX_ADDR,
  input  logic                    DMA_VALID,
  input  logic [ADDRESS_BITS-1:0] DMA_ADDR,
  input  logic                    DMA_WR,
  input  logic [BITS-1:0]         DMA_WDATA,
  output logic                    CPU_READY,
  output logic                    GFX_READY,
  output logic                    DMA_READY,
  output logic                    CPU_RVALID,
  output logic                    GFX_RVALID,
  output logic                    DMA_RVALID,
  output logic [BITS-1:0]         RDATA,
  output logic [ADDRESS_BITS-1:0] MEM_ADDR,
  output logic [BITS-1:0]         MEM_WDATA,
  output logic                    MEM_WR,
  input  logic [BITS-1:0]         MEM_RDATA
);

  rr_sel_e                 rr_last_q, rr_last_d;
  owner_e                  rd_owner_q, rd_owner_d;
  logic [ADDRESS_BITS-1:0] mem_addr_q;
  logic                    gnt_cpu, gnt_gfx, gnt_dma;
  logic                    gfx_urgent, dma_urgent;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_starve_limit_out_of_range
  end

`ifdef MEMORY_ARBITER_STARVE_GUARD_EN
  starve_counter #(.LIMIT(STARVE_LIMIT)) u_gfx_starve (
    .clk_i   (CLK),
    .rst_n_i (RSTb),
    .valid_i (GFX_VALID),
    .grant_i (gnt_gfx),
    .over_o  (gfx_urgent)
  );

  starve_counter #(.LIMIT(STARVE_LIMIT)) u_dma_starve (
    .clk_i   (CLK),
    .rst_n_i (RSTb),
    .valid_i (DMA_VALID),
    .grant_i (gnt_dma),
    .over_o  (dma_urgent)
  );
`else
  assign gfx_urgent = 1'b0;
  assign dma_urgent = 1'b0;
`endif

  // Grants are held off while in reset so nothing reaches memory.
  always_comb begin
    gnt_cpu = 1'b0;
    gnt_gfx = 1'b0;
    gnt_dma = 1'b0;
    if (RSTb) begin
      if (gfx_urgent || dma_urgent) begin
        gnt_gfx = rr_pick_gfx(gfx_urgent, dma_urgent, rr_last_q);
        gnt_dma = !gnt_gfx;
      end else if (CPU_VALID) begin
        gnt_cpu = 1'b1;
      end else if (GFX_VALID || DMA_VALID) begin
        gnt_gfx = rr_pick_gfx(GFX_VALID, DMA_VALID, rr_last_q);
        gnt_dma = !gnt_gfx;
      end
    end
  end

  always_comb begin
    MEM_ADDR  = RSTb ? mem_addr_q : '0;
    MEM_WDATA = '0;
    MEM_WR    = 1'b0;
    if (gnt_cpu) begin
      MEM_ADDR  = CPU_ADDR;
      MEM_WDATA = CPU_WDATA;
      MEM_WR    = CPU_WR;
    end else if (gnt_gfx) begin
      MEM_ADDR  = GFX_ADDR;
    end else if (gnt_dma) begin
      MEM_ADDR  = DMA_ADDR;
      MEM_WDATA = DMA_WDATA;
      MEM_WR    = DMA_WR;
    end
  end

  always_comb begin
    rr_last_d  = rr_last_q;
    rd_owner_d = OWN_NONE;
    if (gnt_gfx) rr_last_d = RR_GFX;
    if (gnt_dma) rr_last_d = RR_DMA;
    if (gnt_cpu && !CPU_WR) rd_owner_d = OWN_CPU;
    if (gnt_gfx)            rd_owner_d = OWN_GFX;
    if (gnt_dma && !DMA_WR) rd_owner_d = OWN_DMA;
  end

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      rr_last_q  <= RR_DMA;
      rd_owner_q <= OWN_NONE;
      mem_addr_q <= '0;
    end else begin
      rr_last_q  <= rr_last_d;
      rd_owner_q <= rd_owner_d;
      mem_addr_q <= MEM_ADDR;
    end
  end

  assign CPU_READY  = gnt_cpu;
  assign GFX_READY  = gnt_gfx;
  assign DMA_READY  = gnt_dma;
  // Gating with RSTb drops a read return that lands in a reset cycle.
  assign CPU_RVALID = RSTb && (rd_owner_q == OWN_CPU);
  assign GFX_RVALID = RSTb && (rd_owner_q == OWN_GFX);
  assign DMA_RVALID = RSTb && (rd_owner_q == OWN_DMA);
  assign RDATA      = MEM_RDATA;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a one-cycle-latency SPRAM model.
module tb_memory_arbiter;

  localparam int AW = 15;
  localparam int DW = 16;

  logic          CLK = 1'b0;
  logic          RSTb;
  logic          CPU_VALID, GFX_VALID, DMA_VALID;
  logic [AW-1:0] CPU_ADDR, GFX_ADDR, DMA_ADDR;
  logic          CPU_WR, DMA_WR;
  logic [DW-1:0] CPU_WDATA, DMA_WDATA;
  logic          CPU_READY, GFX_READY, DMA_READY;
  logic          CPU_RVALID, GFX_RVALID, DMA_RVALID;
  logic [DW-1:0] RDATA;
  logic [AW-1:0] MEM_ADDR;
  logic [DW-1:0] MEM_WDATA;
  logic          MEM_WR;
  logic [DW-1:0] MEM_RDATA;

  int total = 0;
  int fails = 0;

  wire [2:0] rdy = {CPU_READY, GFX_READY, DMA_READY};
  wire [2:0] rv  = {CPU_RVALID, GFX_RVALID, DMA_RVALID};

  always #5 CLK = ~CLK;

  memory_arbiter #(.ADDRESS_BITS(AW), .BITS(DW), .STARVE_LIMIT(4)) dut (
    .CLK(CLK), .RSTb(RSTb),
    .CPU_VALID(CPU_VALID), .CPU_ADDR(CPU_ADDR), .CPU_WR(CPU_WR), .CPU_WDATA(CPU_WDATA),
    .GFX_VALID(GFX_VALID), .GFX_ADDR(GFX_ADDR),
    .DMA_VALID(DMA_VALID), .DMA_ADDR(DMA_ADDR), .DMA_WR(DMA_WR), .DMA_WDATA(DMA_WDATA),
    .CPU_READY(CPU_READY), .GFX_READY(GFX_READY), .DMA_READY(DMA_READY),
    .CPU_RVALID(CPU_RVALID), .GFX_RVALID(GFX_RVALID), .DMA_RVALID(DMA_RVALID),
    .RDATA(RDATA), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_WR(MEM_WR),
    .MEM_RDATA(MEM_RDATA)
  );

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge CLK) begin
    if (MEM_WR) mem[MEM_ADDR] <= MEM_WDATA;
    MEM_RDATA <= mem[MEM_ADDR];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    CPU_VALID = 1'b0; GFX_VALID = 1'b0; DMA_VALID = 1'b0;
    CPU_WR = 1'b0; DMA_WR = 1'b0;
    CPU_WDATA = '0; DMA_WDATA = '0;
  endtask

  initial begin
    idle();
    CPU_ADDR = '0; GFX_ADDR = '0; DMA_ADDR = '0;
    RSTb = 1'b0;
    CPU_VALID = 1'b1; GFX_VALID = 1'b1; DMA_VALID = 1'b1;
    #1;

    // Reset held three cycles with every requester asking.
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("rst_ready", rdy, 3'b000);
      check("rst_rvalid", rv, 3'b000);
      check("rst_mem_wr", MEM_WR, 1'b0);
      check("rst_mem_addr", MEM_ADDR, 0);
      next_cycle();
    end
    RSTb = 1'b1;
    @(negedge CLK);
    check("post_rst_cpu_first", rdy, 3'b100);
    next_cycle();

    // CPU writes, then reads back.
    idle();
    CPU_VALID = 1'b1; CPU_WR = 1'b1; CPU_ADDR = 15'h0123; CPU_WDATA = 16'hBEEF;
    @(negedge CLK);
    check("cpu_wr_ready", rdy, 3'b100);
    check("cpu_wr_mem_wr", MEM_WR, 1'b1);
    check("cpu_wr_mem_addr", MEM_ADDR, 15'h0123);
    check("cpu_wr_mem_wdata", MEM_WDATA, 16'hBEEF);
    next_cycle();
    CPU_ADDR = 15'h0100; CPU_WDATA = 16'h1111;
    next_cycle();
    CPU_ADDR = 15'h0200; CPU_WDATA = 16'h2222;
    @(negedge CLK);
    check("cpu_wr2_rvalid", rv, 3'b000);
    next_cycle();
    CPU_WR = 1'b0; CPU_ADDR = 15'h0123; CPU_WDATA = '0;
    @(negedge CLK);
    check("cpu_rd_ready", rdy, 3'b100);
    check("cpu_rd_mem_wr", MEM_WR, 1'b0);
    check("wr_no_rvalid", rv, 3'b000);
    next_cycle();
    idle();
    @(negedge CLK);
    check("cpu_rvalid", rv, 3'b100);
    check("cpu_rdata", RDATA, 16'hBEEF);
    check("idle_ready", rdy, 3'b000);
    check("idle_addr_hold", MEM_ADDR, 15'h0123);
    check("idle_wdata", MEM_WDATA, 0);
    check("idle_mem_wr", MEM_WR, 1'b0);
    next_cycle();

    // GFX and DMA contend with the CPU idle: strict alternation, GFX first.
    GFX_VALID = 1'b1; GFX_ADDR = 15'h0100;
    DMA_VALID = 1'b1; DMA_ADDR = 15'h0200;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      check("rr_grant", rdy, (k % 2 == 0) ? 3'b010 : 3'b001);
      if (k == 0) begin
        check("rr_rvalid0", rv, 3'b000);
      end else begin
        check("rr_rvalid", rv, (k % 2 == 1) ? 3'b010 : 3'b001);
        check("rr_rdata", RDATA, (k % 2 == 1) ? 16'h1111 : 16'h2222);
      end
      next_cycle();
    end
    idle();
    @(negedge CLK);
    check("rr_last_rvalid", rv, 3'b001);
    check("rr_last_rdata", RDATA, 16'h2222);
    next_cycle();

`ifdef MEMORY_ARBITER_STARVE_GUARD_EN
    // CPU and GFX both asking: GFX preempts on every fifth cycle.
    CPU_VALID = 1'b1; CPU_ADDR = 15'h0123;
    GFX_VALID = 1'b1; GFX_ADDR = 15'h0100;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      check("starve_grant", rdy, (k == 4 || k == 9) ? 3'b010 : 3'b100);
      if (k == 5) begin
        check("starve_rvalid", rv, 3'b010);
        check("starve_rdata", RDATA, 16'h1111);
      end
      next_cycle();
    end
`else
    // CPU holds the memory; GFX and DMA never win.
    CPU_VALID = 1'b1; CPU_ADDR = 15'h0123;
    GFX_VALID = 1'b1; DMA_VALID = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      check("cpu_strict_grant", rdy, 3'b100);
      next_cycle();
    end
`endif
    idle();
    next_cycle();

    // DMA read granted, then reset lands on its return cycle.
    DMA_VALID = 1'b1; DMA_ADDR = 15'h0200;
    @(negedge CLK);
    check("dma_rd_ready", rdy, 3'b001);
    next_cycle();
    idle();
    RSTb = 1'b0;
    @(negedge CLK);
    check("rst_mid_read_rvalid", rv, 3'b000);
    next_cycle();
    RSTb = 1'b1;
    @(negedge CLK);
    check("after_rst_rvalid", rv, 3'b000);
    next_cycle();

    // Leave GFX as last winner, reset, then a tie must still go to GFX.
    GFX_VALID = 1'b1; GFX_ADDR = 15'h0100;
    @(negedge CLK);
    check("gfx_single", rdy, 3'b010);
    next_cycle();
    idle();
    RSTb = 1'b0;
    next_cycle();
    RSTb = 1'b1;
    GFX_VALID = 1'b1; DMA_VALID = 1'b1;
    @(negedge CLK);
    check("rst_tie_gfx", rdy, 3'b010);
    check("rst_tie_rvalid", rv, 3'b000);
    next_cycle();
    @(negedge CLK);
    check("rst_tie_then_dma", rdy, 3'b001);
    check("rst_tie_gfx_rvalid", rv, 3'b010);
    next_cycle();
    idle();
    next_cycle();

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Arbitrates single-port SPRAM access between three requesters: CPU, graphics fetch and DMA. One access per clock. CPU has fixed top priority, GFX and DMA share the remaining slots round-robin, and an optional starvation guard bounds how long a low-priority requester can wait. The block sits between the requesters and the memory wrapper and drives its address, write-data and write-enable inputs.

## Interface
- ADDRESS_BITS, 15: requester and memory address width
- BITS, 16: data width
- STARVE_LIMIT, 8: wait-cycle limit for the starvation guard (1..255)
- CLK  in  1  system clock
- RSTb  in  1  synchronous, active-low reset
- CPU_VALID / GFX_VALID / DMA_VALID  in  1 each  access request
- CPU_ADDR / GFX_ADDR / DMA_ADDR  in  ADDRESS_BITS each  request address
- CPU_WR / DMA_WR  in  1 each  write request (GFX is read-only)
- CPU_WDATA / DMA_WDATA  in  BITS each  write data
- CPU_READY / GFX_READY / DMA_READY  out  1 each  grant; the access is taken this cycle
- CPU_RVALID / GFX_RVALID / DMA_RVALID  out  1 each  read data valid on RDATA
- RDATA  out  BITS  read data, shared by all requesters
- MEM_ADDR  out  ADDRESS_BITS  to memory
- MEM_WDATA  out  BITS  to memory
- MEM_WR  out  1  to memory
- MEM_RDATA  in  BITS  from memory (one-cycle read latency)

## Operation
- Grant is combinational from the VALID inputs and registered arbiter state. Exactly zero or one READY is high in any cycle.
- Priority: CPU > round-robin(GFX, DMA). A one-bit `rr_last` register records which of GFX/DMA was last granted. When both are valid and the CPU is idle, the one not named by `rr_last` wins. `rr_last` updates only on a GFX or DMA grant.
- The granted requester's ADDR, WDATA and WR are muxed onto the MEM_* outputs in the same cycle.
- MEM_WR = granted & WR. GFX grants always drive MEM_WR=0.
- When nothing is granted: MEM_WR=0, MEM_ADDR holds its last value (registered copy), MEM_WDATA=0.
- Read return: a registered `rd_owner` (2 bits: none/CPU/GFX/DMA) is captured on each read grant. The next cycle asserts the matching *_RVALID for one cycle. RDATA=MEM_RDATA passes through combinationally.
- Writes produce no RVALID.
- A requester holds VALID, ADDR and WDATA stable until it sees READY. Dropping VALID before READY is legal; the request is then lost with no side effect.
- Back-to-back grants to the same requester are legal. Each read yields one RVALID pulse, in order.

## Timing
- Reset (RSTb=0 at a CLK edge): all READY=0 during reset, RVALID=0, MEM_WR=0, MEM_ADDR=0, `rr_last`=DMA (so GFX wins the first tie), `rd_owner`=none, starvation counters=0.
- Reset asserted mid-read: the pending RVALID is suppressed, and the data is not returned.
- Read latency: READY in cycle N, RVALID and RDATA in cycle N+1.
- Throughput: one access per cycle. A write may immediately follow a read with no bubble.
- Simultaneous CPU and GFX valid in the same cycle: the CPU is granted and GFX stalls.

## Configuration
- `MEMORY_ARBITER_STARVE_GUARD_EN` defined:
  - Each of GFX and DMA has an 8-bit wait counter.
  - The counter increments each cycle that requester's VALID is high without READY, saturating at 255. It clears on grant or when VALID is low.
  - When a counter is ≥ STARVE_LIMIT, that requester preempts the CPU for one grant.
  - If both counters are over the limit, the round-robin rule picks between GFX and DMA.
- Undefined: counters are absent, and CPU priority is strict; the CPU can starve GFX and DMA indefinitely.

## Structure
- Shared package `memory_arbiter_pkg`: the `rd_owner` encoding constants (OWN_NONE=0, OWN_CPU=1, OWN_GFX=2, OWN_DMA=3) and the default STARVE_LIMIT.
- One natural sub-module, `starve_counter`: a saturating 8-bit wait counter with an over-limit flag, instantiated twice when the guard is enabled.

## Test plan
- Reset: hold RSTb=0 for 3 cycles with all VALID=1 -> all READY=0, RVALID=0, MEM_WR=0. After release, the CPU is granted first.
- CPU write then read: write 0xBEEF to 0x0123, then read 0x0123 -> CPU_READY on each request cycle, CPU_RVALID one cycle after the read grant, RDATA=0xBEEF.
- GFX/DMA contention with CPU idle: both valid continuously for 6 cycles -> grants alternate GFX, DMA, GFX, DMA, GFX, DMA, and each GFX read returns GFX_RVALID one cycle later.
- CPU contention: CPU, GFX and DMA all valid -> the CPU is granted every cycle. Without the guard, GFX and DMA never get READY.
- Starvation guard (macro defined, STARVE_LIMIT=4): CPU and GFX continuously valid -> GFX_READY on the 5th cycle, then the CPU resumes. The GFX counter is back at 0 after the grant.
- Reset mid-read: a DMA read is granted in cycle N and RSTb=0 in cycle N+1 -> DMA_RVALID stays 0.
